axis_cmd_parser: RTL

- Upstream control stage for the AXI-Stream BRAM data mover.
- Receives a fixed 7-word command packet on a dedicated AXI-Stream slave and validates it.
- Commits the fields atomically to the mover's FSM control inputs: Instruction_code, wr/rd BRAM range, address start and count.
- Holds the fields stable until the mover reports write_done/read_done, then returns Instruction_code to NOP.

---
 rtl/axis_cmd_parser_pkg.sv | 44 ++++
 rtl/axis_cmd_validator.sv | 28 ++
 rtl/axis_cmd_parser.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_cmd_parser_pkg.sv
// Shared definitions for the command parser: opcodes, packet word indices,
// FSM state encoding and the shadow/command field bundle.
package axis_cmd_parser_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_WR_RD  = 8'h03;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int CMD_WORDS = 7;

  localparam logic [2:0] W_CODE    = 3'd0;
  localparam logic [2:0] W_WR_BANK = 3'd1;
  localparam logic [2:0] W_WR_ADDR = 3'd2;
  localparam logic [2:0] W_WR_CNT  = 3'd3;
  localparam logic [2:0] W_RD_BANK = 3'd4;
  localparam logic [2:0] W_RD_ADDR = 3'd5;
  localparam logic [2:0] W_RD_CNT  = 3'(CMD_WORDS - 1);

  // Write bank field is 5 bits wide but only banks 0..15 exist in the mover.
  localparam logic [4:0] WR_BANK_MAX = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0]  code;
    logic [4:0]  wr_bram_start;
    logic [4:0]  wr_bram_end;
    logic [15:0] wr_addr_start;
    logic [15:0] wr_addr_count;
    logic [2:0]  rd_bram_start;
    logic [2:0]  rd_bram_end;
    logic [15:0] rd_addr_start;
    logic [15:0] rd_addr_count;
  } cmd_fields_t;

endpackage

// File: rtl/axis_cmd_validator.sv
// Combinational sanity check of a fully assembled command before it is
// handed to the mover.
module axis_cmd_validator
  import axis_cmd_parser_pkg::*;
(
  input  cmd_fields_t fields,
  output logic        pass
);

  logic is_write;
  logic is_read;
  logic code_bad;
  logic wr_bad;
  logic rd_bad;

  always_comb begin
    is_write = (fields.code == OP_WRITE) || (fields.code == OP_WR_RD);
    is_read  = (fields.code == OP_READ)  || (fields.code == OP_WR_RD);
    code_bad = fields.code > OP_WR_RD;
    wr_bad   = is_write && ((fields.wr_bram_start > fields.wr_bram_end) ||
                            (fields.wr_bram_end > WR_BANK_MAX) ||
                            (fields.wr_addr_count == 16'd0));
    rd_bad   = is_read  && ((fields.rd_bram_start > fields.rd_bram_end) ||
                            (fields.rd_addr_count == 16'd0));
    pass     = !(code_bad || wr_bad || rd_bad);
  end

endmodule

// File: rtl/axis_cmd_parser.sv
// Receives 7-word command packets on AXI-Stream, validates them and commits
// the fields atomically to the mover's control inputs until it reports done.
module axis_cmd_parser
  import axis_cmd_parser_pkg::*;
#(
  parameter int         CMD_WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         ERR_CNT_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [CMD_WIDTH-1:0]     s_axis_cmd_tdata,
  input  logic                     s_axis_cmd_tvalid,
  output logic                     s_axis_cmd_tready,
  input  logic                     s_axis_cmd_tlast,
  output logic [7:0]               Instruction_code,
  output logic [4:0]               wr_bram_start,
  output logic [4:0]               wr_bram_end,
  output logic [15:0]              wr_addr_start,
  output logic [15:0]              wr_addr_count,
  output logic [2:0]               rd_bram_start,
  output logic [2:0]               rd_bram_end,
  output logic [15:0]              rd_addr_start,
  output logic [15:0]              rd_addr_count,
  input  logic                     write_done,
  input  logic                     read_done,
  output logic                     cmd_busy,
  output logic                     cmd_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  state_e                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  cmd_fields_t              shadow_q, shadow_d;
  cmd_fields_t              out_q, out_d;
  logic                     busy_q, busy_d;
  logic                     error_q, error_d;
  logic                     tready_q, tready_d;
  logic                     wd_seen_q, wd_seen_d;
  logic                     rd_seen_q, rd_seen_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [15:0] word;
  logic        accept;
  logic        val_pass;
  logic        err_event;
  logic        wd_now;
  logic        rd_now;
  logic        exec_done;
  logic        unused_tdata;

  assign word         = s_axis_cmd_tdata[15:0];
  assign accept       = s_axis_cmd_tvalid && tready_q;
  assign unused_tdata = ^s_axis_cmd_tdata;

  // Shadow register collects the packet; validator sees it including the word in flight.
  always_comb begin
    shadow_d = shadow_q;
    if (accept && (state_q == ST_IDLE) && (word[15:8] == SYNC_BYTE)) begin
      shadow_d.code = word[7:0];
    end else if (accept && (state_q == ST_RECV)) begin
      case (idx_q)
        W_WR_BANK: begin
          shadow_d.wr_bram_end   = word[12:8];
          shadow_d.wr_bram_start = word[4:0];
        end
        W_WR_ADDR: shadow_d.wr_addr_start = word;
        W_WR_CNT:  shadow_d.wr_addr_count = word;
        W_RD_BANK: begin
          shadow_d.rd_bram_end   = word[10:8];
          shadow_d.rd_bram_start = word[2:0];
        end
        W_RD_ADDR: shadow_d.rd_addr_start = word;
        W_RD_CNT:  shadow_d.rd_addr_count = word;
        default: ;
      endcase
    end
  end

  axis_cmd_validator u_validator (
    .fields (shadow_d),
    .pass   (val_pass)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_d     = out_q;
    busy_d    = (state_q == ST_EXEC) ? busy_q : 1'b0;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    wd_seen_d = wd_seen_q;
    rd_seen_d = rd_seen_q;
    err_event = 1'b0;
    wd_now    = wd_seen_q || write_done;
    rd_now    = rd_seen_q || read_done;

    case (out_q.code)
      OP_WRITE: exec_done = wd_now;
      OP_READ:  exec_done = rd_now;
      OP_WR_RD: exec_done = wd_now && rd_now;
      default:  exec_done = 1'b1;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((word[15:8] == SYNC_BYTE) && !s_axis_cmd_tlast) begin
            idx_d   = W_WR_BANK;
            state_d = ST_RECV;
          end else begin
            err_event = 1'b1;
            state_d   = s_axis_cmd_tlast ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          if (idx_q == W_RD_CNT) begin
            if (!s_axis_cmd_tlast) begin
              err_event = 1'b1;
              state_d   = ST_DRAIN;
            end else if (val_pass) begin
              out_d   = shadow_d;
              busy_d  = 1'b1;
              error_d = 1'b0;
              state_d = (shadow_d.code == OP_NOP) ? ST_IDLE : ST_EXEC;
            end else begin
              err_event = 1'b1;
              state_d   = ST_IDLE;
            end
          end else if (s_axis_cmd_tlast) begin
            err_event = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          out_d.code = OP_NOP;
          busy_d     = 1'b0;
          wd_seen_d  = 1'b0;
          rd_seen_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          wd_seen_d = wd_now;
          rd_seen_d = rd_now;
        end
      end
      ST_DRAIN: begin
        if (accept && s_axis_cmd_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_event) begin
      error_d = 1'b1;
      if (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end

    tready_d = (state_d != ST_EXEC);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      shadow_q  <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      tready_q  <= 1'b1;
      wd_seen_q <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      tready_q  <= tready_d;
      wd_seen_q <= wd_seen_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  assign s_axis_cmd_tready = tready_q;
  assign Instruction_code  = out_q.code;
  assign wr_bram_start     = out_q.wr_bram_start;
  assign wr_bram_end       = out_q.wr_bram_end;
  assign wr_addr_start     = out_q.wr_addr_start;
  assign wr_addr_count     = out_q.wr_addr_count;
  assign rd_bram_start     = out_q.rd_bram_start;
  assign rd_bram_end       = out_q.rd_bram_end;
  assign rd_addr_start     = out_q.rd_addr_start;
  assign rd_addr_count     = out_q.rd_addr_count;
  assign cmd_busy          = busy_q;
  assign cmd_error         = error_q;
  assign err_count         = err_cnt_q;

endmodule
